// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// No logic here; imported by ifu_fetch and ifu_byte_queue.
package ifu_pkg;

    localparam int ADDR_W        = 32;
    localparam int BYTE_W        = 8;
    localparam int IFU_DEPTH_DEF = 6;

    typedef enum logic [1:0] {
        IFU_IDLE   = 2'd0,
        IFU_STREAM = 2'd1,
        IFU_FULL   = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ifu_byte_queue.sv
// Shift queue of fetched bytes: byte 0 is always the oldest entry.
// Latency: push/pop take effect at the next edge; caller must not push when full or over-pop.
module ifu_byte_queue
    import ifu_pkg::*;
#(
    parameter int DEPTH = IFU_DEPTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] push_dat_i,
    input  logic              pop1_i,
    input  logic              pop2_i,
    output logic [BYTE_W-1:0] byte0_o,
    output logic [BYTE_W-1:0] byte1_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [BYTE_W-1:0] q_q   [DEPTH];
    logic [BYTE_W-1:0] q_d   [DEPTH];
    logic [BYTE_W-1:0] ext   [DEPTH+2];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  pop_w;
    logic [CNT_W-1:0]  tail;
    logic [1:0]        pop_n;

    // Two zero pad slots let the shift read past the tail without range checks.
    always_comb begin
        pop_n   = {pop2_i, pop1_i & ~pop2_i};
        pop_w   = {{(CNT_W-2){1'b0}}, pop_n};
        tail    = count_q - pop_w;
        count_d = count_q - pop_w + {{(CNT_W-1){1'b0}}, push_i};
        for (int i = 0; i < DEPTH; i++) begin
            ext[i] = q_q[i];
        end
        ext[DEPTH]   = '0;
        ext[DEPTH+1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = ext[i + int'(pop_n)];
            if (push_i && (CNT_W'(i) == tail)) begin
                q_d[i] = push_dat_i;
            end
        end
        if (flush_i) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    assign byte0_o = q_q[0];
    assign byte1_o = q_q[1];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: prefetches bytes into a queue and presents MBR1/MBR2 (IFU_SIGN_EXT_EN adds mbr1_sx/mbr2_sx).
// Latency: request cycle N -> MBR1 in N+1; Fetch stalls while the queue is full, pc_load flushes.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int DEPTH = IFU_DEPTH_DEF
) (
    input  logic              clk_ifu,
    input  logic              reset_ifu_n,
    input  logic              ifu_en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_new,
    input  logic              consume1,
    input  logic              consume2,
    output logic [ADDR_W-1:0] PC_M,
    output logic              Fetch,
    input  logic [BYTE_W-1:0] out_MBR,
    output logic [BYTE_W-1:0] MBR1,
    output logic [15:0]       MBR2,
    output logic              mbr1_valid,
    output logic              mbr2_valid,
    output logic [ADDR_W-1:0] pc_ifu,
    output logic              ifu_err
`ifdef IFU_SIGN_EXT_EN
    ,
    output logic [31:0]       mbr1_sx,
    output logic [31:0]       mbr2_sx
`endif
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] pc_head_q, pc_head_d;
    logic              err_q, err_d;

    logic [3:0]        q_count;
    logic [3:0]        cnt_next;
    logic [BYTE_W-1:0] q_byte0, q_byte1;
    logic              want1, want2, ok1, ok2, underflow;
    logic              pop1, pop2;

    assign Fetch = (state_q == IFU_STREAM) && (q_count < DEPTH_C) && !pc_load;
    assign PC_M  = fetch_addr_q;

    // consume1+consume2 together behave as consume2 but still flag an error.
    always_comb begin
        want2     = consume2;
        want1     = consume1 && !consume2;
        ok2       = want2 && (q_count >= 4'd2);
        ok1       = want1 && (q_count != 4'd0);
        underflow = (want2 && !ok2) || (want1 && !ok1) || (consume1 && consume2);
        pop2      = ok2 && !pc_load;
        pop1      = ok1 && !pc_load;
        err_d     = err_q | (underflow && !pc_load);
        if (pc_load) begin
            cnt_next     = 4'd0;
            pc_head_d    = pc_new;
            fetch_addr_d = pc_new;
        end else begin
            cnt_next     = q_count + {3'b0, Fetch} - {2'b0, pop2, pop1};
            pc_head_d    = pc_head_q + {{(ADDR_W-2){1'b0}}, pop2, pop1};
            fetch_addr_d = Fetch ? fetch_addr_q + 32'd1 : fetch_addr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: begin
                if (ifu_en) state_d = IFU_STREAM;
            end
            IFU_STREAM: begin
                if (!ifu_en)                  state_d = IFU_IDLE;
                else if (cnt_next == DEPTH_C) state_d = IFU_FULL;
            end
            IFU_FULL: begin
                if (!ifu_en)                 state_d = IFU_IDLE;
                else if (cnt_next < DEPTH_C) state_d = IFU_STREAM;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
        if (!reset_ifu_n) begin
            state_q      <= IFU_IDLE;
            fetch_addr_q <= '0;
            pc_head_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            pc_head_q    <= pc_head_d;
            err_q        <= err_d;
        end
    end

    ifu_byte_queue #(
        .DEPTH (DEPTH),
        .CNT_W (4)
    ) u_queue (
        .clk_i      (clk_ifu),
        .rst_ni     (reset_ifu_n),
        .flush_i    (pc_load),
        .push_i     (Fetch),
        .push_dat_i (out_MBR),
        .pop1_i     (pop1),
        .pop2_i     (pop2),
        .byte0_o    (q_byte0),
        .byte1_o    (q_byte1),
        .count_o    (q_count)
    );

    assign mbr1_valid = (q_count >= 4'd1);
    assign mbr2_valid = (q_count >= 4'd2);
    assign MBR1       = mbr1_valid ? q_byte0 : '0;
    assign MBR2       = mbr2_valid ? {q_byte0, q_byte1} : '0;
    assign pc_ifu     = pc_head_q;
    assign ifu_err    = err_q;

`ifdef IFU_SIGN_EXT_EN
    assign mbr1_sx = {{24{MBR1[7]}}, MBR1};
    assign mbr2_sx = {{16{MBR2[15]}}, MBR2};
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a falling-edge fetch memory mem[a] = a[7:0] + 8'h10.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk_ifu = 1'b0;
    logic        reset_ifu_n = 1'b0;
    logic        ifu_en = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_new = 32'h0;
    logic        consume1 = 1'b0;
    logic        consume2 = 1'b0;
    logic [7:0]  out_MBR = 8'h0;
    logic [31:0] PC_M;
    logic        Fetch;
    logic [7:0]  MBR1;
    logic [15:0] MBR2;
    logic        mbr1_valid, mbr2_valid;
    logic [31:0] pc_ifu;
    logic        ifu_err;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] flog[$];
    int          fcyc[$];

    ifu_fetch #(.DEPTH(6)) dut (
        .clk_ifu     (clk_ifu),
        .reset_ifu_n (reset_ifu_n),
        .ifu_en      (ifu_en),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .consume1    (consume1),
        .consume2    (consume2),
        .PC_M        (PC_M),
        .Fetch       (Fetch),
        .out_MBR     (out_MBR),
        .MBR1        (MBR1),
        .MBR2        (MBR2),
        .mbr1_valid  (mbr1_valid),
        .mbr2_valid  (mbr2_valid),
        .pc_ifu      (pc_ifu),
        .ifu_err     (ifu_err)
    );

    always #5 clk_ifu = ~clk_ifu;

    always @(posedge clk_ifu) cyc++;

    always @(negedge clk_ifu) begin
        if (Fetch) begin
            out_MBR = PC_M[7:0] + 8'h10;
            flog.push_back(PC_M);
            fcyc.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_ifu);
        #1;
    endtask

    task automatic test_reset();
        reset_ifu_n = 1'b0;
        repeat (2) @(posedge clk_ifu);
        #2;
        checks++;
        if (PC_M !== 32'h0) begin errors++; $display("FAIL reset_pcm: got %h want 0", PC_M); end
        checks++;
        if ({Fetch, mbr1_valid, mbr2_valid, ifu_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {Fetch, mbr1_valid, mbr2_valid, ifu_err});
        end
        checks++;
        if ({MBR1, MBR2} !== 24'h0) begin errors++; $display("FAIL reset_mbr: got %h want 0", {MBR1, MBR2}); end
        checks++;
        if (pc_ifu !== 32'h0) begin errors++; $display("FAIL reset_pc_ifu: got %h want 0", pc_ifu); end
        checks++;
        if (dut.state_q !== IFU_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        tick();
        reset_ifu_n = 1'b1;
    endtask

    task automatic test_fill();
        flog.delete();
        fcyc.delete();
        ifu_en = 1'b1;
        repeat (10) tick();
        #1;
        checks++;
        if (flog.size() !== 6) begin errors++; $display("FAIL fill_count: got %0d fetches want 6", flog.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < flog.size()) begin
                checks++;
                if (flog[i] !== 32'(i) || fcyc[i] !== fcyc[0] + i) begin
                    errors++; $display("FAIL fill_addr%0d: got addr %h cyc %0d want addr %h cyc %0d", i, flog[i], fcyc[i], i, fcyc[0] + i);
                end
            end
        end
        checks++;
        if (Fetch !== 1'b0 || dut.state_q !== IFU_FULL) begin
            errors++; $display("FAIL fill_full: got Fetch %b state %0d want 0 FULL", Fetch, dut.state_q);
        end
        checks++;
        if (MBR1 !== 8'h10 || MBR2 !== 16'h1011) begin errors++; $display("FAIL fill_mbr: got %h %h want 10 1011", MBR1, MBR2); end
        checks++;
        if (pc_ifu !== 32'h0) begin errors++; $display("FAIL fill_pc_ifu: got %h want 0", pc_ifu); end
    endtask

    task automatic test_consume1();
        logic [7:0] exp_b;
        flog.delete();
        fcyc.delete();
        consume1 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            exp_b = 8'h10 + 8'(k);
            checks++;
            if (MBR1 !== exp_b) begin errors++; $display("FAIL consume1_mbr1_%0d: got %h want %h", k, MBR1, exp_b); end
            checks++;
            if (dut.q_count !== 4'd5 && dut.q_count !== 4'd6) begin
                errors++; $display("FAIL consume1_count_%0d: got %0d want 5 or 6", k, dut.q_count);
            end
        end
        checks++;
        if (flog.size() !== 7) begin
            errors++; $display("FAIL consume1_fetches: got %0d want 7", flog.size());
        end else begin
            checks++;
            if (flog[0] !== 32'd6 || flog[6] !== 32'd12) begin
                errors++; $display("FAIL consume1_addrs: got %h..%h want 6..c", flog[0], flog[6]);
            end
        end
        checks++;
        if (pc_ifu !== 32'd8) begin errors++; $display("FAIL consume1_pc_ifu: got %h want 8", pc_ifu); end
        consume1 = 1'b0;
    endtask

    task automatic test_redirect();
        tick();
        pc_load = 1'b1;
        pc_new  = 32'h20;
        tick();
        pc_load = 1'b0;
        repeat (4) tick();
        pc_load = 1'b1;
        pc_new  = 32'h40;
        #1;
        checks++;
        if (dut.q_count !== 4'd4 || MBR1 !== 8'h30) begin
            errors++; $display("FAIL redir_pre: got count %0d MBR1 %h want 4 30", dut.q_count, MBR1);
        end
        checks++;
        if (Fetch !== 1'b0) begin errors++; $display("FAIL redir_fetch0: got %b want 0", Fetch); end
        tick();
        pc_load = 1'b0;
        #1;
        checks++;
        if (PC_M !== 32'h40 || Fetch !== 1'b1) begin
            errors++; $display("FAIL redir_pcm: got %h fetch %b want 40 1", PC_M, Fetch);
        end
        checks++;
        if (mbr1_valid !== 1'b0 || pc_ifu !== 32'h40) begin
            errors++; $display("FAIL redir_flush: got valid %b pc_ifu %h want 0 40", mbr1_valid, pc_ifu);
        end
        ifu_en = 1'b0;
        tick();
        #1;
        checks++;
        if (MBR1 !== 8'h50 || mbr1_valid !== 1'b1 || pc_ifu !== 32'h40) begin
            errors++; $display("FAIL redir_mbr1: got %h valid %b pc %h want 50 1 40", MBR1, mbr1_valid, pc_ifu);
        end
    endtask

    task automatic test_underflow();
        checks++;
        if (ifu_err !== 1'b0 || dut.q_count !== 4'd1) begin
            errors++; $display("FAIL under_pre: got err %b count %0d want 0 1", ifu_err, dut.q_count);
        end
        consume2 = 1'b1;
        tick();
        consume2 = 1'b0;
        #1;
        checks++;
        if (dut.q_count !== 4'd1 || MBR1 !== 8'h50) begin
            errors++; $display("FAIL under_hold: got count %0d MBR1 %h want 1 50", dut.q_count, MBR1);
        end
        checks++;
        if (ifu_err !== 1'b1 || mbr2_valid !== 1'b0) begin
            errors++; $display("FAIL under_err: got err %b v2 %b want 1 0", ifu_err, mbr2_valid);
        end
        repeat (3) tick();
        #1;
        checks++;
        if (ifu_err !== 1'b1) begin errors++; $display("FAIL under_sticky: got %b want 1", ifu_err); end
    endtask

    task automatic test_wrap();
        tick();
        ifu_en  = 1'b1;
        pc_load = 1'b1;
        pc_new  = 32'hFFFF_FFFE;
        tick();
        pc_load = 1'b0;
        #1;
        checks++;
        if (PC_M !== 32'hFFFF_FFFE || Fetch !== 1'b1) begin
            errors++; $display("FAIL wrap_a0: got %h fetch %b want fffffffe 1", PC_M, Fetch);
        end
        tick();
        #1;
        checks++;
        if (PC_M !== 32'hFFFF_FFFF || MBR1 !== 8'h0E || pc_ifu !== 32'hFFFF_FFFE) begin
            errors++; $display("FAIL wrap_a1: got %h MBR1 %h pc %h want ffffffff 0e fffffffe", PC_M, MBR1, pc_ifu);
        end
        tick();
        #1;
        checks++;
        if (PC_M !== 32'h0 || MBR2 !== 16'h0E0F) begin
            errors++; $display("FAIL wrap_a2: got %h MBR2 %h want 0 0e0f", PC_M, MBR2);
        end
        tick();
        #1;
        checks++;
        if (PC_M !== 32'h1 || ifu_err !== 1'b1) begin
            errors++; $display("FAIL wrap_a3: got %h err %b want 1 1", PC_M, ifu_err);
        end
    endtask

    task automatic test_async_reset();
        #1;
        reset_ifu_n = 1'b0;
        #1;
        checks++;
        if (Fetch !== 1'b0 || PC_M !== 32'h0 || pc_ifu !== 32'h0) begin
            errors++; $display("FAIL areset_addr: got fetch %b pcm %h pc %h want 0 0 0", Fetch, PC_M, pc_ifu);
        end
        checks++;
        if ({MBR1, MBR2} !== 24'h0 || {mbr1_valid, mbr2_valid, ifu_err} !== 3'b000) begin
            errors++; $display("FAIL areset_mbr: got %h flags %b want 0 000", {MBR1, MBR2}, {mbr1_valid, mbr2_valid, ifu_err});
        end
        checks++;
        if (dut.state_q !== IFU_IDLE) begin errors++; $display("FAIL areset_state: got %0d want IDLE", dut.state_q); end
        ifu_en = 1'b0;
        tick();
        reset_ifu_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume1();
        test_redirect();
        test_underflow();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: the initiator side of the byte-wide fetch-memory port (PC_M / Fetch / out_MBR). It prefetches bytes from the fetch memory into a byte queue ahead of the datapath. It presents the head of the queue as an 8-bit MBR1 and a big-endian 16-bit MBR2, and accepts redirects (branches/jumps) from the control unit. It sits between the fetch memory and the MIC datapath/control store.

## Interface
- DEPTH, 6: queue capacity in bytes; legal range 2..15.
- clk_ifu  in  1  clock; all state updates on rising edge.
- reset_ifu_n  in  1  asynchronous, active-low reset.
- ifu_en  in  1  level; enables fetching (IDLE -> STREAM).
- pc_load  in  1  redirect strobe, one cycle.
- pc_new  in  32  redirect target byte address.
- consume1  in  1  datapath consumed 1 byte this cycle.
- consume2  in  1  datapath consumed 2 bytes this cycle.
- PC_M  out  32  fetch-memory byte address (combinational from registered state).
- Fetch  out  1  fetch request to memory (combinational from registered state).
- out_MBR  in  8  byte returned by the fetch memory.
- MBR1  out  8  queue byte 0; 8'h00 when not valid.
- MBR2  out  16  {queue byte 0, queue byte 1}; 16'h0000 when not valid.
- mbr1_valid  out  1  count ≥ 1.
- mbr2_valid  out  1  count ≥ 2.
- pc_ifu  out  32  byte address of queue byte 0.
- ifu_err  out  1  sticky underflow/illegal-consume flag; cleared only by reset.

## Operation
- State: fetch_addr[31:0], pc_head[31:0], count[3:0], queue[DEPTH][8], 2-bit FSM.
- FSM states:
  - IDLE: after reset. Fetch=0. Moves to STREAM when ifu_en=1.
  - STREAM: Fetch=1 when count<DEPTH. Moves to FULL when the next count equals DEPTH.
  - FULL: Fetch=0. Moves to STREAM when the next count is below DEPTH.
  - ifu_en=0 in STREAM or FULL returns the FSM to IDLE. Queue contents are kept.
- Fetch = (state==STREAM) && (count<DEPTH) && !pc_load.
- PC_M = fetch_addr.
- Capture: if Fetch was 1 during the cycle, append out_MBR at the closing rising edge and increment fetch_addr (mod 2^32).
- Consume: consume1 removes 1 byte and consume2 removes 2 bytes. Each removal shifts the queue toward byte 0 and advances pc_head by the same amount.
- Simultaneous consume and capture:
  - Shift first, then append at the new tail.
  - count_next = count + captured − consumed.
- Underflow: consume1 with count=0, or consume2 with count<2.
  - The consume is ignored entirely.
  - ifu_err is set.
  - Capture still occurs.
- consume1 and consume2 together: treated as consume2, and ifu_err is set.
- pc_load has priority over everything at that edge:
  - queue flushed (count=0);
  - fetch_addr = pc_head = pc_new;
  - consumes ignored;
  - no capture (Fetch is already 0 that cycle).
- Address wrap: 32'hFFFFFFFF + 1 = 0. No fault is raised.
- MBR2 is big-endian: MBR2[15:8] = byte 0.

## Timing
- Reset values: PC_M=0, Fetch=0, MBR1=0, MBR2=0, mbr1_valid=0, mbr2_valid=0, pc_ifu=0, ifu_err=0, state IDLE.
- Memory contract: the memory samples PC_M/Fetch on the falling edge inside the request cycle. out_MBR is stable before the next rising edge.
- Fetch latency: a request in cycle N becomes a queue entry after the rising edge ending cycle N. It is visible on MBR1 in cycle N+1 if the queue was empty.
- Throughput: 1 byte/cycle.
- Redirect latency: pc_load in cycle N → first fetch at pc_new in cycle N+1 → MBR1 valid in cycle N+2.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous). Fetch drops combinationally.

## Configuration
- IFU_SIGN_EXT_EN defined: adds two ports.
  - mbr1_sx  out  32: MBR1 sign-extended.
  - mbr2_sx  out  32: MBR2 sign-extended.
  - Both are 0 when the corresponding valid flag is low.
- IFU_SIGN_EXT_EN undefined: the ports and their logic are absent. Every other behaviour is identical.

## Structure
- Package ifu_pkg holds:
  - the FSM enum ifu_state_t (IFU_IDLE, IFU_STREAM, IFU_FULL);
  - ADDR_W=32 and BYTE_W=8;
  - the default DEPTH.
- One sub-module, ifu_byte_queue:
  - parameterised shift queue;
  - push, pop-1/pop-2 and flush;
  - outputs byte 0, byte 1 and count.
- ifu_fetch holds the FSM, the address registers and the error flag.

## Test plan
Bench uses a behavioural fetch memory with mem[a] = a[7:0] + 8'h10 and the same falling-edge sampling.
- Reset, then ifu_en=1 with no consumes:
  - required: addresses 0..5 are fetched on consecutive cycles, then Fetch=0 and state FULL;
  - MBR1=8'h10, MBR2=16'h1011, pc_ifu=0.
- Full queue, then consume1 every cycle:
  - required: MBR1 steps 8'h11, 8'h12, …;
  - one fetch per cycle and count stays at DEPTH−1 or DEPTH.
- pc_load with pc_new=32'h40 while 4 bytes are queued:
  - required: Fetch=0 that cycle, then PC_M=32'h40 next cycle;
  - MBR1=8'h50 two cycles after pc_load; pc_ifu=32'h40.
- Consume2 with count=1:
  - required: count unchanged and MBR1 unchanged;
  - ifu_err=1 and stays 1 until reset.
- pc_new=32'hFFFFFFFE with no consumes:
  - required: PC_M goes FFFFFFFE, FFFFFFFF, 0, 1;
  - MBR2=16'h0E0F.
- reset_ifu_n pulsed low mid-stream, off-edge:
  - required: all outputs reach their reset values immediately, with no clock edge needed.
